// File: rtl/alu_acc_seq_if.sv
// alu_acc_seq_if: operand/opcode handshake and registered result/flag bundle
interface alu_acc_seq_if #(
  parameter int WIDTH = 32
);
  logic in_valid, in_ready, acc_sel, out_valid, carry, zero, error;
  logic [WIDTH-1:0] a, b, result;
  logic [3:0] opCode;
  modport master(
    output in_valid, a, b, opCode, acc_sel,
    input in_ready, result, out_valid, carry, zero, error
  );
  modport slave(
    input in_valid, a, b, opCode, acc_sel,
    output in_ready, result, out_valid, carry, zero, error
  );
endinterface

// File: rtl/alu_acc_seq.sv
// alu_acc_seq: registered ALU with accumulate mode, valid/ready handshake and shift-add multiply
module alu_acc_seq #(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic reset,
  alu_acc_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, MUL} state_t;
  state_t state, state_d;
  logic [WIDTH-1:0] op_a, alu_res, res_q, mplier;
  logic [WIDTH:0] sum, diff;
  logic [2*WIDTH-1:0] mcand, prod, prod_next;
  logic [CW-1:0] cnt;
  logic alu_carry, legal, accept, last, carry_q, zero_q, error_q, valid_q;
  assign accept = bus.in_valid && state == IDLE;
  assign last = cnt == CW'(WIDTH - 1);
  assign prod_next = prod + (mplier[0] ? mcand : '0);
  assign bus.in_ready = state == IDLE;
  assign bus.result = res_q;
  assign bus.carry = carry_q;
  assign bus.zero = zero_q;
  assign bus.error = error_q;
  assign bus.out_valid = valid_q;
  // state register; reset aborts any multiply in flight
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_d;
  // enter MUL on an accepted multiply, leave on its final iteration
  always_comb begin
    state_d = state;
    if (state == IDLE && accept && bus.opCode == 4'd9) state_d = MUL;
    else if (state == MUL && last) state_d = IDLE;
  end
  // single-cycle opcode decode; accumulate mode feeds the held result in as operand A
  always_comb begin
    op_a = bus.acc_sel ? res_q : bus.a;
    sum = {1'b0, op_a} + {1'b0, bus.b};
    diff = {1'b0, op_a} - {1'b0, bus.b};
    alu_res = res_q;
    alu_carry = carry_q;
    legal = 1'b1;
    case (bus.opCode)
      4'd0, 4'd9: ;
      4'd1: begin alu_res = '0; alu_carry = 1'b0; end
      4'd3: begin alu_res = op_a | bus.b; alu_carry = 1'b0; end
      4'd5: begin alu_res = op_a & bus.b; alu_carry = 1'b0; end
      4'd6: begin alu_res = sum[WIDTH-1:0]; alu_carry = sum[WIDTH]; end
      4'd8: begin alu_res = diff[WIDTH-1:0]; alu_carry = diff[WIDTH]; end
      4'd12: begin alu_res = WIDTH'(op_a == bus.b); alu_carry = 1'b0; end
      4'd13: begin alu_res = WIDTH'(op_a > bus.b); alu_carry = 1'b0; end
      4'd14: begin alu_res = WIDTH'(op_a < bus.b); alu_carry = 1'b0; end
      default: legal = 1'b0;
    endcase
  end
  // result/flag registers and the shift-add multiplier datapath
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      res_q <= '0;
      carry_q <= 1'b0;
      zero_q <= 1'b1;
      error_q <= 1'b0;
      valid_q <= 1'b0;
      mcand <= '0;
      mplier <= '0;
      prod <= '0;
      cnt <= '0;
    end else begin
      valid_q <= 1'b0;
      if (state == MUL) begin
        prod <= prod_next;
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
        cnt <= cnt + 1'b1;
        if (last) begin
          res_q <= prod_next[WIDTH-1:0];
          carry_q <= |prod_next[2*WIDTH-1:WIDTH];
          zero_q <= prod_next[WIDTH-1:0] == '0;
          error_q <= 1'b0;
          valid_q <= 1'b1;
        end
      end else if (accept) begin
        if (bus.opCode == 4'd9) begin
          mcand <= {{WIDTH{1'b0}}, op_a};
          mplier <= bus.b;
          prod <= '0;
          cnt <= '0;
        end else begin
          res_q <= alu_res;
          carry_q <= alu_carry;
          zero_q <= alu_res == '0;
          error_q <= !legal;
          valid_q <= 1'b1;
        end
      end
    end
endmodule
